// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-network step scheduler:
//   - state_t        : scheduler FSM states
//   - *_DEF          : default sizing of the datapath
// No ports (package).
// -----------------------------------------------------------------------------
package snn_pkg;

    localparam int N_IN_DEF    = 16;
    localparam int N_OUT_DEF   = 2;
    localparam int T_STEPS_DEF = 100;
    localparam int CNT_W_DEF   = 8;
    localparam int STEP_W_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ACCUM   = 3'd2,
        DRAIN   = 3'd3,
        UPDATE  = 3'd4,
        CAPTURE = 3'd5,
        HOLD    = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage

// File: rtl/snn_spike_tally.sv
// -----------------------------------------------------------------------------
// snn_spike_tally
// Saturating spike counters, one per output neuron, plus the max-compare that
// produces the winner vector.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clr          zero all counters
//   i_capture      add i_spike into the counters (saturating)
//   i_latch        register the winner vector (evaluated on the post-capture
//                  counts, so the final timestep is included)
//   i_win_clr      clear the winner vector
//   i_spike        neuron fire flags
//   o_win          registered winner flags
// -----------------------------------------------------------------------------
module snn_spike_tally #(
    parameter int N_OUT = 2,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_capture,
    input  logic             i_latch,
    input  logic             i_win_clr,
    input  logic [N_OUT-1:0] i_spike,
    output logic [N_OUT-1:0] o_win
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt     [N_OUT];
    logic [CNT_W-1:0] w_cnt_nxt [N_OUT];
    logic [CNT_W-1:0] w_max;
    logic [N_OUT-1:0] w_win;
    logic [N_OUT-1:0] r_win;

    always_comb begin
        w_max = '0;
        w_win = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (i_capture && i_spike[i] && (r_cnt[i] != CNT_MAX)) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
            if (w_cnt_nxt[i] > w_max) begin
                w_max = w_cnt_nxt[i];
            end
        end
        // All-zero counts produce no winner; ties light every tied output.
        for (int i = 0; i < N_OUT; i++) begin
            w_win[i] = (w_cnt_nxt[i] == w_max) && (w_max != '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_cnt[i] <= '0;
            end
            r_win <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                r_cnt[i] <= i_clr ? '0 : w_cnt_nxt[i];
            end
            if (i_win_clr) begin
                r_win <= '0;
            end else if (i_latch) begin
                r_win <= w_win;
            end
        end
    end

    assign o_win = r_win;

endmodule

// File: rtl/snn_step_scheduler.sv
// -----------------------------------------------------------------------------
// snn_step_scheduler
// Sequencer for the spiking-network datapath: runs T_STEPS timesteps, each one
// walking all input synapse addresses, then strobing leak/fire and capturing
// the output spikes. Reports winner(s) when the run completes and pauses at
// timestep boundaries when the run switch drops.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for run=1
// CLEAR   | nrn_clr pulse, counters and step index zeroed
// ACCUM   | syn_addr walks 0..N_IN-1, acc_en follows one cycle later
// DRAIN   | acc_en for the last address
// UPDATE  | upd_en pulse (leak + threshold)
// CAPTURE | spike_in sampled into the tally; decide done / hold / next step
// HOLD    | paused between timesteps, no strobes
// DONE    | done=1, win held until run drops
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_run           run switch level
//   o_nrn_clr       neuron clear pulse at run start
//   o_syn_addr      synapse address (memories have 1-cycle read latency)
//   o_acc_en        accumulate strobe, address valid delayed by one cycle
//   o_upd_en        leak/fire strobe
//   i_spike_in      neuron fire flags, valid the cycle after o_upd_en
//   o_step_idx      current timestep
//   o_busy          running (not IDLE/DONE)
//   o_hold          paused at a timestep boundary
//   o_done          run complete
//   o_win           winner flags, valid while o_done=1
// -----------------------------------------------------------------------------
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int T_STEPS = T_STEPS_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STEP_W  = STEP_W_DEF,
    localparam int ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_run,
    output logic              o_nrn_clr,
    output logic [ADDR_W-1:0] o_syn_addr,
    output logic              o_acc_en,
    output logic              o_upd_en,
    input  logic [N_OUT-1:0]  i_spike_in,
    output logic [STEP_W-1:0] o_step_idx,
    output logic              o_busy,
    output logic              o_hold,
    output logic              o_done,
    output logic [N_OUT-1:0]  o_win
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_IN - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(T_STEPS - 1);

    state_t            r_state;
    logic              r_nrn_clr;
    logic [ADDR_W-1:0] r_syn_addr;
    logic              r_acc_en;
    logic              r_upd_en;
    logic [STEP_W-1:0] r_step_idx;
    logic              r_busy;
    logic              r_hold;
    logic              r_done;

    logic w_tally_clr;
    logic w_tally_cap;
    logic w_tally_latch;
    logic w_win_clr;

    // Outputs are registered from the state being entered, so every strobe
    // lines up with the cycle its state occupies.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_nrn_clr  <= 1'b0;
            r_syn_addr <= '0;
            r_acc_en   <= 1'b0;
            r_upd_en   <= 1'b0;
            r_step_idx <= '0;
            r_busy     <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_nrn_clr <= 1'b0;
            r_acc_en  <= 1'b0;
            r_upd_en  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_run) begin
                        r_state    <= CLEAR;
                        r_nrn_clr  <= 1'b1;
                        r_step_idx <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_state    <= ACCUM;
                    r_syn_addr <= '0;
                end
                ACCUM: begin
                    r_acc_en <= 1'b1;
                    if (r_syn_addr == ADDR_LAST) begin
                        r_state    <= DRAIN;
                        r_syn_addr <= '0;
                    end else begin
                        r_syn_addr <= r_syn_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    r_state  <= UPDATE;
                    r_upd_en <= 1'b1;
                end
                UPDATE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    if (r_step_idx == STEP_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (!i_run) begin
                        r_state <= HOLD;
                        r_hold  <= 1'b1;
                    end else begin
                        r_state    <= ACCUM;
                        r_step_idx <= r_step_idx + STEP_W'(1);
                    end
                end
                HOLD: begin
                    if (i_run) begin
                        r_state    <= ACCUM;
                        r_hold     <= 1'b0;
                        r_step_idx <= r_step_idx + STEP_W'(1);
                    end
                end
                DONE: begin
                    // Staying here while run is high forces a switch toggle
                    // before the next run.
                    if (!i_run) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_tally_clr   = (r_state == CLEAR);
    assign w_tally_cap   = (r_state == CAPTURE);
    assign w_tally_latch = (r_state == CAPTURE) && (r_step_idx == STEP_LAST);
    assign w_win_clr     = (r_state == DONE) && !i_run;

    snn_spike_tally #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
    ) u_tally (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_tally_clr),
        .i_capture (w_tally_cap),
        .i_latch   (w_tally_latch),
        .i_win_clr (w_win_clr),
        .i_spike   (i_spike_in),
        .o_win     (o_win)
    );

    assign o_nrn_clr  = r_nrn_clr;
    assign o_syn_addr = r_syn_addr;
    assign o_acc_en   = r_acc_en;
    assign o_upd_en   = r_upd_en;
    assign o_step_idx = r_step_idx;
    assign o_busy     = r_busy;
    assign o_hold     = r_hold;
    assign o_done     = r_done;

endmodule

// File: tb/tb_snn_step_scheduler.sv
module tb_snn_step_scheduler;

    localparam int N_IN     = 4;
    localparam int N_OUT    = 2;
    localparam int T_STEPS  = 6;
    localparam int CNT_W    = 2;
    localparam int STEP_W   = 8;
    localparam int ADDR_W   = 2;
    localparam int STEP_CYC = N_IN + 3;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [N_OUT-1:0]  spike_in;
    logic              nrn_clr;
    logic [ADDR_W-1:0] syn_addr;
    logic              acc_en;
    logic              upd_en;
    logic [STEP_W-1:0] step_idx;
    logic              busy;
    logic              hold;
    logic              done;
    logic [N_OUT-1:0]  win;

    snn_step_scheduler #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .T_STEPS (T_STEPS),
        .CNT_W   (CNT_W),
        .STEP_W  (STEP_W)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_run      (run),
        .o_nrn_clr  (nrn_clr),
        .o_syn_addr (syn_addr),
        .o_acc_en   (acc_en),
        .o_upd_en   (upd_en),
        .i_spike_in (spike_in),
        .o_step_idx (step_idx),
        .o_busy     (busy),
        .o_hold     (hold),
        .o_done     (done),
        .o_win      (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_OUT-1:0] win;
        int               clr_cyc;
        int               done_cyc;
        bit               timed;
        int               hold_step;
        bit               aborted;
    } exp_t;

    exp_t             sb[$];
    logic [N_OUT-1:0] pat [T_STEPS];
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    logic             run_q = 1'b0;
    logic             rst_q = 1'b0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        run_q <= run;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: saturating per-neuron spike totals over the whole run, then
    // every neuron holding the nonzero maximum wins.
    function automatic logic [N_OUT-1:0] model_win();
        int cnt [N_OUT];
        int mx;
        logic [N_OUT-1:0] w;
        mx = 0;
        w  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            cnt[i] = 0;
            for (int s = 0; s < T_STEPS; s++) begin
                if (pat[s][i]) cnt[i] = cnt[i] + 1;
            end
            if (cnt[i] > CNT_SAT) cnt[i] = CNT_SAT;
            if (cnt[i] > mx) mx = cnt[i];
        end
        for (int i = 0; i < N_OUT; i++) begin
            w[i] = (mx > 0) && (cnt[i] == mx);
        end
        return w;
    endfunction

    // ---------------- spike driver: real value only in the capture cycle ----
    int drv_step = 0;
    initial begin
        spike_in = '0;
        forever begin
            @(negedge clk);
            if (nrn_clr) drv_step = 0;
            if (upd_en) begin
                @(posedge clk);
                #1;
                spike_in = (drv_step < T_STEPS) ? pat[drv_step] : '0;
                drv_step++;
                @(posedge clk);
                #1;
                spike_in = N_OUT'($urandom);
            end else begin
                spike_in = N_OUT'($urandom);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------------------------
    initial begin
        logic [ADDR_W-1:0] prev_addr;
        int               exp_addr, acc_cnt, acc_step, upd_cnt, hold_val;
        bit               active, hold_seen, prev_hold, prev_done;
        logic [N_OUT-1:0] prev_win;
        logic [2:0]       strobes;
        exp_t             e;
        prev_addr = '0; exp_addr = 0; acc_cnt = 0; acc_step = 0; upd_cnt = 0;
        hold_val = 0; active = 0; hold_seen = 0; prev_hold = 0; prev_done = 0;
        prev_win = '0;
        forever begin
            @(negedge clk);
            strobes = {nrn_clr, acc_en, upd_en};
            if (rst_q) begin
                check("reset_outputs",
                      {19'd0, nrn_clr, syn_addr, acc_en, upd_en, step_idx, busy, hold, done, win}, 0);
                if (active && sb.size() > 0) begin
                    check("abort_record", sb[0].aborted, 1);
                    void'(sb.pop_front());
                end
                active = 0; exp_addr = 0; acc_step = 0;
                prev_done = 0; prev_hold = 0; prev_win = '0;
            end else begin
                if (strobes != 0) check("strobe_onehot", $countones(strobes), 1);
                if (nrn_clr) begin
                    if (sb.size() == 0) begin
                        check("clr_unexpected", 1, 0);
                    end else if (sb[0].timed) begin
                        check("clr_cycle", cyc, sb[0].clr_cyc);
                    end
                    check("clr_step_idx", step_idx, 0);
                    check("clr_busy", busy, 1);
                    active = 1; acc_cnt = 0; acc_step = 0; upd_cnt = 0;
                    exp_addr = 0; hold_seen = 0;
                end
                if (acc_en) begin
                    check("syn_addr", prev_addr, exp_addr);
                    exp_addr = (exp_addr + 1) % N_IN;
                    acc_cnt++;
                    acc_step++;
                end
                if (upd_en) begin
                    check("acc_per_step", acc_step, N_IN);
                    acc_step = 0;
                    upd_cnt++;
                end
                if (hold && !prev_hold) begin
                    hold_seen = 1;
                    hold_val  = step_idx;
                    check("hold_after_full_step", upd_cnt, step_idx + 1);
                    if (sb.size() > 0) check("hold_step", step_idx, sb[0].hold_step);
                    check("hold_busy", busy, 1);
                end
                if (hold) begin
                    check("hold_no_strobe", strobes, 0);
                    check("hold_step_stable", step_idx, hold_val);
                end
                if (done && !prev_done) begin
                    if (sb.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("win", win, e.win);
                        check("acc_total", acc_cnt, T_STEPS * N_IN);
                        check("upd_total", upd_cnt, T_STEPS);
                        check("hold_seen", hold_seen, (e.hold_step >= 0) ? 1 : 0);
                        if (e.timed) check("done_cycle", cyc, e.done_cyc);
                        check("done_step_idx", step_idx, T_STEPS - 1);
                        check("done_busy", busy, 0);
                    end
                    active = 0;
                end else if (prev_done) begin
                    if (run_q) begin
                        check("done_stays", done, 1);
                        check("win_held", win, prev_win);
                        check("no_rerun", nrn_clr, 0);
                    end else begin
                        check("done_release", {done, busy, win}, 0);
                    end
                end
                if (!done) check("win_outside_done", win, 0);
            end
            prev_addr = syn_addr;
            prev_hold = hold;
            prev_done = done;
            prev_win  = win;
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input bit timed, input int hold_step, input bit aborted);
        exp_t e;
        e.win       = model_win();
        e.clr_cyc   = cyc + 1;
        e.done_cyc  = cyc + 2 + T_STEPS * STEP_CYC;
        e.timed     = timed;
        e.hold_step = hold_step;
        e.aborted   = aborted;
        sb.push_back(e);
        run = 1'b1;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            step_cycle();
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic finish_run(input int linger);
        repeat (linger) step_cycle();
        run = 1'b0;
        repeat (3) step_cycle();
    endtask

    task automatic fill_pat(input int mode);
        for (int s = 0; s < T_STEPS; s++) begin
            case (mode)
                0: pat[s] = 2'b01;
                1: pat[s] = 2'b11;
                2: pat[s] = 2'b00;
                3: pat[s] = 2'b10;
                default: pat[s] = N_OUT'($urandom);
            endcase
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b1;
        run = 1'b0;
        repeat (3) step_cycle();
        rst = 1'b0;
        repeat (2) step_cycle();

        // Directed patterns: single winner, tie, no spikes, saturation.
        for (int m = 0; m < 4; m++) begin
            fill_pat(m);
            push_run(1, -1, 0);
            wait_done();
            finish_run(8);
        end

        // Saturation that changes the winner if a counter wraps.
        pat[0] = 2'b11; pat[1] = 2'b11; pat[2] = 2'b11;
        pat[3] = 2'b10; pat[4] = 2'b00; pat[5] = 2'b00;
        push_run(1, -1, 0);
        wait_done();
        finish_run(2);

        // Pause during step 1.
        fill_pat(4);
        push_run(0, 1, 0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (step_idx == 1) begin ok = 1; break; end
            step_cycle();
        end
        if (!ok) check("pause_reach_step1", 0, 1);
        run = 1'b0;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (hold) begin ok = 1; break; end
            step_cycle();
        end
        if (!ok) check("hold_timeout", 0, 1);
        repeat (10) step_cycle();
        run = 1'b1;
        wait_done();
        finish_run(1);

        // Reset during UPDATE of step 1 with run still high.
        fill_pat(4);
        push_run(0, -1, 1);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (step_idx == 1 && upd_en) begin ok = 1; break; end
        end
        if (!ok) check("reset_point_timeout", 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        fill_pat(4);
        rst = 1'b0;
        push_run(1, -1, 0);
        wait_done();
        finish_run(3);

        // Random runs.
        for (int r = 0; r < 6; r++) begin
            fill_pat(4);
            push_run(1, -1, 0);
            wait_done();
            finish_run($urandom_range(0, 4));
        end

        repeat (3) step_cycle();
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
